// File: rtl/i2s_pkg.sv
// Shared definitions for the I2S receive and transmit paths.
package i2s_pkg;

    // Default word width and synchronizer depth.
    localparam int DEF_WIDTH       = 16;
    localparam int DEF_SYNC_STAGES = 2;

    // Receiver frame-tracking states.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LEFT  = 2'd1,
        ST_RIGHT = 2'd2
    } state_t;

    // Word-select polarity.
    localparam logic WS_LEFT  = 1'b0;
    localparam logic WS_RIGHT = 1'b1;

endpackage

// File: rtl/i2s_sync_edge.sv
// N-stage synchronizer for an I2S bit clock plus companion data lanes.
// All lanes see the same depth so they stay aligned, and the bit clock
// lane gets a one-clk rising-edge strobe.
module i2s_sync_edge
    import i2s_pkg::*;
#(
    parameter int STAGES = DEF_SYNC_STAGES,
    parameter int DATA_W = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_edge,
    input  logic [DATA_W-1:0] i_data,
    output logic              o_rise,
    output logic [DATA_W-1:0] o_data
);

    logic [STAGES-1:0]             r_edge_sync;
    logic                          r_edge_d;
    logic [STAGES-1:0][DATA_W-1:0] r_data_sync;

    // Synchronizer chains and the delayed copy used for edge detection.
    // NOTE: every flop in a chain is updated with <= so each stage takes the
    // previous stage's old value; blocking assignments would collapse the chain.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_edge_sync <= '0;
            r_edge_d    <= 1'b0;
            r_data_sync <= '0;
        end else begin
            r_edge_sync[0] <= i_edge;
            r_data_sync[0] <= i_data;
            for (int i = 1; i < STAGES; i++) begin
                r_edge_sync[i] <= r_edge_sync[i-1];
                r_data_sync[i] <= r_data_sync[i-1];
            end
            r_edge_d <= r_edge_sync[STAGES-1];
        end
    end

    assign o_rise = r_edge_sync[STAGES-1] & ~r_edge_d;
    assign o_data = r_data_sync[STAGES-1];

endmodule

// File: rtl/deserializer.sv
// I2S receiver: oversamples sck/ws/sd on the master clock, assembles
// MSB-first words per channel and presents complete stereo pairs.
module deserializer
    import i2s_pkg::*;
#(
    parameter int WIDTH       = DEF_WIDTH,
    parameter int SYNC_STAGES = DEF_SYNC_STAGES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i2si_en,
    input  logic             i2si_sck,
    input  logic             i2si_ws,
    input  logic             i2si_sd,
    output logic [WIDTH-1:0] i2si_lft,
    output logic [WIDTH-1:0] i2si_rgt,
    output logic             rts,
    output logic             frame_err
);

    localparam int              CNT_W    = $clog2(WIDTH + 1);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic             w_sck_rise;
    logic [1:0]       w_lanes;
    logic             w_ws_s;
    logic             w_sd_s;
    logic             w_room;
    logic             w_boundary;
    logic             w_complete;
    logic [CNT_W-1:0] w_cnt_inc;
    logic [WIDTH-1:0] w_shift_next;

    state_t           r_state;
    logic [CNT_W-1:0] r_bit_cnt;
    logic [WIDTH-1:0] r_shift;
    logic [WIDTH-1:0] r_lft_hold;
    logic [WIDTH-1:0] r_lft;
    logic [WIDTH-1:0] r_rgt;
    logic             r_ws_prev;
    logic             r_rts;
    logic             r_frame_err;

    i2s_sync_edge #(
        .STAGES (SYNC_STAGES),
        .DATA_W (2)
    ) u_sync (
        .clk    (clk),
        .rst_n  (rst_n),
        .i_edge (i2si_sck),
        .i_data ({i2si_ws, i2si_sd}),
        .o_rise (w_sck_rise),
        .o_data (w_lanes)
    );

    assign w_ws_s = w_lanes[1];
    assign w_sd_s = w_lanes[0];

    // Bits beyond WIDTH are dropped so long words keep their MSB-justified part.
    assign w_room       = (r_bit_cnt < CNT_FULL);
    assign w_shift_next = w_room ? {r_shift[WIDTH-2:0], w_sd_s} : r_shift;
    assign w_cnt_inc    = w_room ? (r_bit_cnt + CNT_W'(1)) : r_bit_cnt;

    // The boundary bit is already included in w_cnt_inc / w_shift_next.
    assign w_boundary = (w_ws_s != r_ws_prev);
    assign w_complete = (w_cnt_inc >= CNT_FULL);

    // Frame tracking, word assembly and registered output pulses.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_bit_cnt   <= '0;
            r_shift     <= '0;
            r_lft_hold  <= '0;
            r_lft       <= '0;
            r_rgt       <= '0;
            r_ws_prev   <= WS_LEFT;
            r_rts       <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_rts       <= 1'b0;
            r_frame_err <= 1'b0;

            // ws history follows the line even while disabled, so re-enabling
            // never sees a stale transition.
            if (w_sck_rise) begin
                r_ws_prev <= w_ws_s;
            end

            if (!i2si_en) begin
                r_state   <= ST_IDLE;
                r_bit_cnt <= '0;
            end else if (w_sck_rise) begin
                r_shift   <= w_shift_next;
                r_bit_cnt <= w_boundary ? '0 : w_cnt_inc;

                if (w_boundary) begin
                    case (r_state)
                        ST_IDLE: begin
                            if (w_ws_s == WS_LEFT) begin
                                r_state <= ST_LEFT;
                            end
                        end
                        ST_LEFT: begin
                            if (w_complete) begin
                                r_lft_hold <= w_shift_next;
                                r_state    <= ST_RIGHT;
                            end else begin
                                r_frame_err <= 1'b1;
                                r_state     <= ST_IDLE;
                            end
                        end
                        ST_RIGHT: begin
                            // A new left word starts either way.
                            if (w_complete) begin
                                r_lft <= r_lft_hold;
                                r_rgt <= w_shift_next;
                                r_rts <= 1'b1;
                            end else begin
                                r_frame_err <= 1'b1;
                            end
                            r_state <= ST_LEFT;
                        end
                        default: r_state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    assign i2si_lft  = r_lft;
    assign i2si_rgt  = r_rgt;
    assign rts       = r_rts;
    assign frame_err = r_frame_err;

endmodule

// File: tb/tb_deserializer.sv
// Directed bench for the I2S deserializer: sck = clk/16, data changes on the
// sck falling edge, ws switches on the last bit of each word.
module tb_deserializer;
    import i2s_pkg::*;

    localparam int  W        = 16;
    localparam int  HALF     = 8;                 // clk cycles per sck half period
    localparam time T_CLK    = 10;
    localparam time T_FRAME  = 2 * W * 2 * HALF * T_CLK;
    localparam time T_LAT    = 3 * T_CLK;         // sck rise drive -> rts seen

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i2si_en = 1'b0;
    logic         i2si_sck = 1'b0;
    logic         i2si_ws = 1'b1;
    logic         i2si_sd = 1'b0;
    logic [W-1:0] i2si_lft;
    logic [W-1:0] i2si_rgt;
    logic         rts;
    logic         frame_err;

    int n_checks = 0;
    int n_fail   = 0;

    logic [W-1:0] cap_l[$];
    logic [W-1:0] cap_r[$];
    time          cap_t[$];
    int           ferr_cnt  = 0;
    int           both_cnt  = 0;
    int           stray_cnt = 0;
    logic [W-1:0] prev_l = '0;
    logic [W-1:0] prev_r = '0;
    time          t_last_rise = 0;

    always #(T_CLK / 2) clk = ~clk;

    deserializer #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .i2si_en   (i2si_en),
        .i2si_sck  (i2si_sck),
        .i2si_ws   (i2si_ws),
        .i2si_sd   (i2si_sd),
        .i2si_lft  (i2si_lft),
        .i2si_rgt  (i2si_rgt),
        .rts       (rts),
        .frame_err (frame_err)
    );

    // Observe outputs on the falling clk edge, away from DUT updates.
    always @(negedge clk) begin
        if (rts === 1'b1) begin
            cap_l.push_back(i2si_lft);
            cap_r.push_back(i2si_rgt);
            cap_t.push_back($time);
        end
        if (frame_err === 1'b1) ferr_cnt++;
        if (rts === 1'b1 && frame_err === 1'b1) both_cnt++;
        if (rst_n && rts !== 1'b1 && (i2si_lft !== prev_l || i2si_rgt !== prev_r)) stray_cnt++;
        prev_l = i2si_lft;
        prev_r = i2si_rgt;
    end

    task automatic send_bit(input logic ws, input logic sd);
        i2si_ws = ws;
        i2si_sd = sd;
        repeat (HALF) @(negedge clk);
        i2si_sck    = 1'b1;
        t_last_rise = $time;
        repeat (HALF) @(negedge clk);
        i2si_sck = 1'b0;
    endtask

    // MSB first; ws flips to the other channel on the final bit.
    task automatic send_word(input logic ch, input logic [31:0] data, input int nbits);
        for (int i = nbits - 1; i >= 0; i--) begin
            send_bit((i == 0) ? ~ch : ch, data[i]);
        end
    endtask

    task automatic send_frame(input logic [W-1:0] l, input logic [W-1:0] r);
        send_word(WS_LEFT, 32'(l), W);
        send_word(WS_RIGHT, 32'(r), W);
    endtask

    task automatic test_reset();
        repeat (4) @(negedge clk);
        n_checks++; if (i2si_lft !== 16'h0000) begin n_fail++; $display("FAIL reset_lft: got %h expected 0000", i2si_lft); end
        n_checks++; if (i2si_rgt !== 16'h0000) begin n_fail++; $display("FAIL reset_rgt: got %h expected 0000", i2si_rgt); end
        n_checks++; if (rts !== 1'b0) begin n_fail++; $display("FAIL reset_rts: got %b expected 0", rts); end
        n_checks++; if (frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b expected 0", frame_err); end
        #2 rst_n = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_normal();
        int  b_r, b_f;
        time lat;
        b_r = cap_l.size();
        b_f = ferr_cnt;
        i2si_en = 1'b1;
        send_word(WS_RIGHT, 32'h0, 4);        // tail of a right word, then left starts
        send_frame(16'hA5C3, 16'h1234);
        n_checks++; if (cap_l.size() - b_r !== 1) begin n_fail++; $display("FAIL normal_rts_count: got %0d expected 1", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'hA5C3) begin n_fail++; $display("FAIL normal_lft: got %h expected a5c3", cap_l[b_r]); end
        n_checks++; if (cap_r[b_r] !== 16'h1234) begin n_fail++; $display("FAIL normal_rgt: got %h expected 1234", cap_r[b_r]); end
        n_checks++; if (ferr_cnt - b_f !== 0) begin n_fail++; $display("FAIL normal_frame_err: got %0d expected 0", ferr_cnt - b_f); end
        lat = cap_t[b_r] - t_last_rise;
        n_checks++; if (lat !== T_LAT) begin n_fail++; $display("FAIL normal_latency: got %0t expected %0t", lat, T_LAT); end
    endtask

    task automatic test_mid_frame();
        int b_r, b_f;
        i2si_en = 1'b0;
        send_word(WS_LEFT, 32'h5A5A, W);
        for (int i = 0; i < 5; i++) send_bit(WS_RIGHT, 1'b1);
        i2si_en = 1'b1;
        b_r = cap_l.size();
        b_f = ferr_cnt;
        for (int i = 0; i < 10; i++) send_bit(WS_RIGHT, 1'b0);
        send_bit(WS_LEFT, 1'b1);
        n_checks++; if (cap_l.size() - b_r !== 0) begin n_fail++; $display("FAIL mid_partial_rts: got %0d expected 0", cap_l.size() - b_r); end
        send_frame(16'h1111, 16'h2222);
        send_frame(16'h3333, 16'h4444);
        n_checks++; if (cap_l.size() - b_r !== 2) begin n_fail++; $display("FAIL mid_rts_count: got %0d expected 2", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'h1111 || cap_r[b_r] !== 16'h2222) begin n_fail++; $display("FAIL mid_pair1: got %h/%h expected 1111/2222", cap_l[b_r], cap_r[b_r]); end
        n_checks++; if (cap_l[b_r+1] !== 16'h3333 || cap_r[b_r+1] !== 16'h4444) begin n_fail++; $display("FAIL mid_pair2: got %h/%h expected 3333/4444", cap_l[b_r+1], cap_r[b_r+1]); end
        n_checks++; if (ferr_cnt - b_f !== 0) begin n_fail++; $display("FAIL mid_frame_err: got %0d expected 0", ferr_cnt - b_f); end
    endtask

    task automatic test_short();
        int b_r, b_f;
        b_r = cap_l.size();
        b_f = ferr_cnt;
        send_word(WS_LEFT, 32'hABC, 12);      // short left word
        n_checks++; if (ferr_cnt - b_f !== 1) begin n_fail++; $display("FAIL short_left_err: got %0d expected 1", ferr_cnt - b_f); end
        send_word(WS_RIGHT, 32'h0, W);        // ignored while resyncing
        send_frame(16'h0BEE, 16'h0CAF);
        n_checks++; if (cap_l.size() - b_r !== 1) begin n_fail++; $display("FAIL short_rts_count: got %0d expected 1", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'h0BEE || cap_r[b_r] !== 16'h0CAF) begin n_fail++; $display("FAIL short_pair: got %h/%h expected 0bee/0caf", cap_l[b_r], cap_r[b_r]); end
        // Short right word: pair dropped, outputs held.
        b_r = cap_l.size();
        b_f = ferr_cnt;
        send_word(WS_LEFT, 32'h1357, W);
        send_word(WS_RIGHT, 32'h2A5, 10);
        n_checks++; if (ferr_cnt - b_f !== 1) begin n_fail++; $display("FAIL short_right_err: got %0d expected 1", ferr_cnt - b_f); end
        n_checks++; if (cap_l.size() - b_r !== 0) begin n_fail++; $display("FAIL short_right_rts: got %0d expected 0", cap_l.size() - b_r); end
        n_checks++; if (i2si_lft !== 16'h0BEE || i2si_rgt !== 16'h0CAF) begin n_fail++; $display("FAIL short_right_hold: got %h/%h expected 0bee/0caf", i2si_lft, i2si_rgt); end
        send_frame(16'hDEAD, 16'hBEEF);       // left already started by the short right LSB
        n_checks++; if (cap_l.size() - b_r !== 1) begin n_fail++; $display("FAIL short_recover_rts: got %0d expected 1", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'hDEAD || cap_r[b_r] !== 16'hBEEF) begin n_fail++; $display("FAIL short_recover_pair: got %h/%h expected dead/beef", cap_l[b_r], cap_r[b_r]); end
    endtask

    task automatic test_long();
        int b_r, b_f;
        b_r = cap_l.size();
        b_f = ferr_cnt;
        send_word(WS_LEFT, {14'h0, 16'hFFFE, 2'b01}, 18);
        send_word(WS_RIGHT, {14'h0, 16'h8001, 2'b10}, 18);
        n_checks++; if (cap_l.size() - b_r !== 1) begin n_fail++; $display("FAIL long_rts_count: got %0d expected 1", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'hFFFE || cap_r[b_r] !== 16'h8001) begin n_fail++; $display("FAIL long_pair: got %h/%h expected fffe/8001", cap_l[b_r], cap_r[b_r]); end
        n_checks++; if (ferr_cnt - b_f !== 0) begin n_fail++; $display("FAIL long_frame_err: got %0d expected 0", ferr_cnt - b_f); end
    endtask

    task automatic test_reset_mid();
        int b_r, b_f;
        send_word(WS_LEFT, 32'h7777, W);
        for (int i = 0; i < 7; i++) send_bit(WS_RIGHT, 1'b1);   // bits 15..9
        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (i2si_lft !== 16'h0000 || i2si_rgt !== 16'h0000) begin n_fail++; $display("FAIL rstmid_outputs: got %h/%h expected 0000/0000", i2si_lft, i2si_rgt); end
        n_checks++; if (rts !== 1'b0) begin n_fail++; $display("FAIL rstmid_rts: got %b expected 0", rts); end
        #2 rst_n = 1'b1;
        b_r = cap_l.size();
        b_f = ferr_cnt;
        for (int i = 0; i < 8; i++) send_bit(WS_RIGHT, 1'b0);   // bits 8..1
        send_bit(WS_LEFT, 1'b1);                                 // bit 0
        n_checks++; if (cap_l.size() - b_r !== 0) begin n_fail++; $display("FAIL rstmid_no_rts: got %0d expected 0", cap_l.size() - b_r); end
        send_frame(16'hAAAA, 16'h5555);
        n_checks++; if (cap_l.size() - b_r !== 1) begin n_fail++; $display("FAIL rstmid_rts_count: got %0d expected 1", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'hAAAA || cap_r[b_r] !== 16'h5555) begin n_fail++; $display("FAIL rstmid_pair: got %h/%h expected aaaa/5555", cap_l[b_r], cap_r[b_r]); end
        n_checks++; if (ferr_cnt - b_f !== 0) begin n_fail++; $display("FAIL rstmid_frame_err: got %0d expected 0", ferr_cnt - b_f); end
    endtask

    task automatic test_back_to_back();
        int           b_r, b_f, b_s;
        logic [W-1:0] exp_l, exp_r;
        time          gap;
        b_r = cap_l.size();
        b_f = ferr_cnt;
        b_s = stray_cnt;
        for (int i = 0; i < 8; i++) send_frame(W'(16'h1100 + i), W'(16'h2200 + i));
        n_checks++; if (cap_l.size() - b_r !== 8) begin n_fail++; $display("FAIL b2b_rts_count: got %0d expected 8", cap_l.size() - b_r); end
        for (int k = 0; k < 8; k++) begin
            exp_l = W'(16'h1100 + k);
            exp_r = W'(16'h2200 + k);
            n_checks++; if (cap_l[b_r+k] !== exp_l || cap_r[b_r+k] !== exp_r) begin n_fail++; $display("FAIL b2b_pair%0d: got %h/%h expected %h/%h", k, cap_l[b_r+k], cap_r[b_r+k], exp_l, exp_r); end
            if (k > 0) begin
                gap = cap_t[b_r+k] - cap_t[b_r+k-1];
                n_checks++; if (gap !== T_FRAME) begin n_fail++; $display("FAIL b2b_gap%0d: got %0t expected %0t", k, gap, T_FRAME); end
            end
        end
        n_checks++; if (stray_cnt - b_s !== 0) begin n_fail++; $display("FAIL b2b_stable: got %0d changes expected 0", stray_cnt - b_s); end
        n_checks++; if (ferr_cnt - b_f !== 0) begin n_fail++; $display("FAIL b2b_frame_err: got %0d expected 0", ferr_cnt - b_f); end
        // Disable mid-left, re-enable mid-right: that frame yields nothing.
        b_r = cap_l.size();
        b_f = ferr_cnt;
        for (int i = 0; i < 5; i++) send_bit(WS_LEFT, 1'b1);
        i2si_en = 1'b0;
        for (int i = 0; i < 10; i++) send_bit(WS_LEFT, 1'b0);
        send_bit(WS_RIGHT, 1'b0);
        for (int i = 0; i < 6; i++) send_bit(WS_RIGHT, 1'b1);
        i2si_en = 1'b1;
        for (int i = 0; i < 9; i++) send_bit(WS_RIGHT, 1'b1);
        send_bit(WS_LEFT, 1'b1);
        n_checks++; if (cap_l.size() - b_r !== 0) begin n_fail++; $display("FAIL en_low_no_rts: got %0d expected 0", cap_l.size() - b_r); end
        n_checks++; if (i2si_lft !== 16'h1107 || i2si_rgt !== 16'h2207) begin n_fail++; $display("FAIL en_low_hold: got %h/%h expected 1107/2207", i2si_lft, i2si_rgt); end
        send_frame(16'hC0DE, 16'hF00D);
        n_checks++; if (cap_l.size() - b_r !== 1) begin n_fail++; $display("FAIL en_resync_rts: got %0d expected 1", cap_l.size() - b_r); end
        n_checks++; if (cap_l[b_r] !== 16'hC0DE || cap_r[b_r] !== 16'hF00D) begin n_fail++; $display("FAIL en_resync_pair: got %h/%h expected c0de/f00d", cap_l[b_r], cap_r[b_r]); end
        n_checks++; if (ferr_cnt - b_f !== 0) begin n_fail++; $display("FAIL en_resync_frame_err: got %0d expected 0", ferr_cnt - b_f); end
        n_checks++; if (both_cnt !== 0) begin n_fail++; $display("FAIL rts_with_frame_err: got %0d expected 0", both_cnt); end
    endtask

    initial begin
        test_reset();
        test_normal();
        test_mid_frame();
        test_short();
        test_long();
        test_reset_mid();
        test_back_to_back();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
